// File: rtl/main_mem_responder_if.sv
// Main-memory request/response bundle between the cache (master) and the
// memory responder (slave). Fields mirror the mem_req / mem_data records.
interface main_mem_responder_if;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic         req_rw;     // 1 = write-back, 0 = line read
  logic         req_valid;
  logic [127:0] rsp_data;
  logic         rsp_ready;  // one-cycle completion pulse

  modport master (
    output req_addr, req_data, req_rw, req_valid,
    input  rsp_data, rsp_ready
  );

  modport slave (
    input  req_addr, req_data, req_rw, req_valid,
    output rsp_data, rsp_ready
  );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts line read / line write requests, waits a
// fixed latency (RD_LAT / WR_LAT) and answers with a one-cycle ready pulse.
// Optional macro MEM_LAT_JITTER_EN adds 0..3 cycles of LFSR-driven latency
// per request.
// Lines are stored XOR'd with their power-up pattern, so a zero-initialised
// storage array reads back as the required init image (line i = 32 nibbles
// of (i mod 15)+1) without any reset or init sweep touching the contents.
module main_mem_responder #(
  parameter int IDX_W  = 10,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  main_mem_responder_if.slave  mem_if,
  output logic                 busy
);

  localparam int DEPTH   = 2 ** IDX_W;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 4) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RD_LD  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_WR_LD  = CNT_W'(WR_LAT - 1);

  // Power-up pattern of a line: its (index mod 15)+1 nibble, replicated.
  function automatic logic [127:0] init_line(input logic [IDX_W-1:0] idx);
    logic [3:0] nib;
    nib = 4'(32'(idx) % 32'd15) + 4'd1;
    return {32{nib}};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [127:0]     wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [127:0]     data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [127:0]     mem_q [DEPTH];
  logic             mem_we_s;
  logic [127:0]     rd_line_s;
  logic             accept_s;
  logic [CNT_W-1:0] extra_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             unused_addr_s;

  assign req_idx_s     = mem_if.req_addr[IDX_W+3:4];
  // No tags: bits above the index and the byte offset are ignored.
  assign unused_addr_s = ^{mem_if.req_addr[31:IDX_W+4], mem_if.req_addr[3:0]};
  assign accept_s      = (state_q == ST_IDLE) && mem_if.req_valid;
  assign rd_line_s     = mem_q[idx_q] ^ init_line(idx_q);

`ifdef MEM_LAT_JITTER_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (accept_s) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign extra_s = CNT_W'(lfsr_q[1:0]);
`else
  assign extra_s = {CNT_W{1'b0}};
`endif

  // Request FSM: accept in IDLE, count down in BUSY, drop ready in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    data_d   = data_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b0;
        if (accept_s) begin
          idx_d   = req_idx_s;
          wdata_d = mem_if.req_data;
          rw_d    = mem_if.req_rw;
          cnt_d   = (mem_if.req_rw ? CNT_WR_LD : CNT_RD_LD) + extra_s;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_RESP;
          if (rw_q) begin
            mem_we_s = 1'b1;
          end else begin
            data_d = rd_line_s;
          end
        end
      end
      ST_RESP: begin
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      wdata_q <= 128'd0;
      rw_q    <= 1'b0;
      data_q  <= 128'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Line storage, never reset; written only on write completion.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_q] <= wdata_q ^ init_line(idx_q);
    end
  end

  assign mem_if.rsp_data  = data_q;
  assign mem_if.rsp_ready = ready_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed scenarios plus random
// traffic, compared against a simple array/latency reference model.
module tb_main_mem_responder;

  localparam int IDX_W  = 10;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 6;
  localparam int DEPTH  = 1024;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  main_mem_responder_if mem_if ();

  main_mem_responder #(.IDX_W(IDX_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (mem_if),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] ref_mem [DEPTH];
  logic [7:0]   ref_lfsr;
  logic [127:0] last_rd;
  int           lat_run [2][16];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected latency of a freshly accepted request.
  task automatic model_accept(input logic rw, output int lat);
    logic fb;
    lat = rw ? WR_LAT : RD_LAT;
`ifdef MEM_LAT_JITTER_EN
    lat = lat + int'(ref_lfsr % 8'd4);
    fb = ^(ref_lfsr & 8'hB8);
    ref_lfsr = (ref_lfsr << 1) | {7'd0, fb};
`else
    fb = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_if.req_valid = 1'b0;
    ref_lfsr = 8'hA5;
    last_rd = 128'd0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 128'(mem_if.rsp_ready), 128'd0);
    check_val("rst_data", mem_if.rsp_data, 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
  endtask

  // Wait for a ready pulse after the accept edge; returns edges counted.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < MAX_WAIT) begin
      @(posedge clk); #1;
      edges++;
      if (mem_if.rsp_ready) break;
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] addr,
                         input logic [127:0] data, input logic rw, output int lat_got);
    int lat_exp;
    int idx;
    @(negedge clk);
    mem_if.req_addr  = addr;
    mem_if.req_data  = data;
    mem_if.req_rw    = rw;
    mem_if.req_valid = 1'b1;
    @(posedge clk); #1;
    model_accept(rw, lat_exp);
    check_val({tag, "_busy_on"}, 128'(busy), 128'd1);
    wait_ready(lat_got);
    check_val({tag, "_lat"}, 128'(lat_got), 128'(lat_exp));
    check_val({tag, "_busy_off"}, 128'(busy), 128'd0);
    idx = int'(addr[13:4]);
    if (rw) begin
      ref_mem[idx] = data;
      check_val({tag, "_hold"}, mem_if.rsp_data, last_rd);
    end else begin
      last_rd = ref_mem[idx];
      check_val({tag, "_data"}, mem_if.rsp_data, ref_mem[idx]);
    end
    @(negedge clk);
    mem_if.req_valid = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, 128'(mem_if.rsp_ready), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int l1;
    int l2;
    int pulses;
    logic [127:0] wd;
    logic [3:0] nib;

    for (int i = 0; i < DEPTH; i++) begin
      nib = 4'((i % 15) + 1);
      ref_mem[i] = 128'h1111_1111_1111_1111_1111_1111_1111_1111 * nib;
    end
    mem_if.req_addr  = 32'd0;
    mem_if.req_data  = 128'd0;
    mem_if.req_rw    = 1'b0;
    mem_if.req_valid = 1'b0;

    do_reset();

    // Read idx 1 after reset, then the top line (idx 3FF).
    run_txn("rd_idx1", 32'h1111_0010, 128'd0, 1'b0, lat);
    check_val("rd_idx1_const", last_rd, {32{4'h2}});
    run_txn("rd_idx3ff", 32'h0000_3FF0, 128'd0, 1'b0, lat);
    check_val("rd_idx3ff_const", last_rd, {32{4'h4}});

    // Write then read through an aliasing address.
    run_txn("wr_alias", 32'h3333_0010, 128'h1234ABCD, 1'b1, lat);
    run_txn("rd_alias", 32'h1111_0010, 128'd0, 1'b0, lat);
    check_val("rd_alias_const", last_rd, 128'h1234ABCD);

    // Write-back then allocate with valid held high.
    wd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mem_if.req_addr  = 32'h0000_0050;
    mem_if.req_data  = wd;
    mem_if.req_rw    = 1'b1;
    mem_if.req_valid = 1'b1;
    @(posedge clk); #1;
    model_accept(1'b1, l1);
    wait_ready(lat);
    check_val("wballoc_wr_lat", 128'(lat), 128'(l1));
    ref_mem[5] = wd;
    @(negedge clk);
    mem_if.req_rw = 1'b0;
    @(posedge clk); #1;
    check_val("wballoc_resp", 128'(mem_if.rsp_ready), 128'd0);
    @(posedge clk); #1;
    model_accept(1'b0, l2);
    check_val("wballoc_accept", 128'(busy), 128'd1);
    wait_ready(lat);
    check_val("wballoc_rd_lat", 128'(lat), 128'(l2));
    check_val("wballoc_rd_data", mem_if.rsp_data, wd);
    last_rd = wd;
    @(negedge clk);
    mem_if.req_valid = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_if.rsp_ready) pulses++;
    end
    check_val("wballoc_extra_pulses", 128'(pulses), 128'd0);

    // Reset three cycles into a write: no pulse, no array update.
    @(negedge clk);
    mem_if.req_addr  = 32'h0000_0070;
    mem_if.req_data  = 128'hDEAD_BEEF;
    mem_if.req_rw    = 1'b1;
    mem_if.req_valid = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 128'(busy), 128'd0);
    check_val("abort_ready", 128'(mem_if.rsp_ready), 128'd0);
    pulses = 0;
    mem_if.req_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_if.rsp_ready) pulses++;
    end
    check_val("abort_pulses", 128'(pulses), 128'd0);
    do_reset();
    run_txn("abort_rd", 32'h0000_0070, 128'd0, 1'b0, lat);
    check_val("abort_rd_const", last_rd, {32{4'h8}});

    // Random traffic with aliasing upper address bits.
    for (int t = 0; t < 30; t++) begin
      run_txn("rand", $urandom, {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), lat);
    end

    // Latency sequence repeats identically from reset.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int k = 0; k < 16; k++) begin
        run_txn("seq_rd", $urandom, 128'd0, 1'b0, lat);
        lat_run[r][k] = lat;
        check_val("seq_range_lo", 128'(lat >= RD_LAT), 128'd1);
        check_val("seq_range_hi", 128'(lat <= RD_LAT + 3), 128'd1);
      end
    end
    for (int k = 0; k < 16; k++) begin
      check_val("seq_repeat", 128'(lat_run[1][k]), 128'(lat_run[0][k]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
